// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART: parity encodings, receiver
// state codes and the 3-sample majority vote.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] STOP2  = 3'd5;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running 0..div counter, tick on the cycle it
// equals div, synchronous clear so a receiver can realign on a start edge.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_r;

  assign tick = (cnt_r == div);

  // divisor counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr || tick) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: majority-voted bit sampling, runtime parity and
// stop-bit selection, valid/ready output with overrun reporting.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic                 sync1_r, sync2_r;
  logic [2:0]           state_r;
  logic [SW-1:0]        sample_cnt_r;
  logic [BW-1:0]        bit_cnt_r;
  logic                 samp_lo_r, samp_mid_r;
  logic [DATA_BITS-1:0] shreg_r;
  logic                 bit_r, have_bit_r;
  logic                 perr_r, ferr_r;
  logic [1:0]           par_mode_r;
  logic                 two_stop_r;

  logic tick_s, start_s, mid_s, last_s, vote_s, finish_s, par_exp_s, par_en_s;

  assign start_s   = (state_r == IDLE) && !sync2_r;
  assign mid_s     = tick_s && (sample_cnt_r == S_HI);
  assign last_s    = tick_s && (sample_cnt_r == S_LAST);
  assign vote_s    = maj3(samp_lo_r, samp_mid_r, sync2_r);
  assign finish_s  = mid_s && (((state_r == STOP) && !two_stop_r) || (state_r == STOP2));
  assign par_en_s  = (par_mode_r == PAR_EVEN) || (par_mode_r == PAR_ODD);
  assign par_exp_s = (par_mode_r == PAR_ODD) ? ~(^shreg_r) : ^shreg_r;

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_s),
    .div  (baud_div),
    .tick (tick_s)
  );

  // input synchroniser, idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rx_serial;
      sync2_r <= sync1_r;
    end
  end

  // per-bit tick counter and the two early vote samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt_r <= '0;
      samp_lo_r    <= 1'b0;
      samp_mid_r   <= 1'b0;
    end else begin
      if (start_s) begin
        sample_cnt_r <= '0;
      end else if (tick_s && (state_r != IDLE)) begin
        sample_cnt_r <= (sample_cnt_r == S_LAST) ? '0 : sample_cnt_r + SW'(1);
      end
      if (tick_s && (sample_cnt_r == S_LO)) samp_lo_r <= sync2_r;
      if (tick_s && (sample_cnt_r == S_MID)) samp_mid_r <= sync2_r;
    end
  end

  // frame state machine; data bits are voted mid-bit and shifted at bit end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      bit_cnt_r  <= '0;
      shreg_r    <= '0;
      bit_r      <= 1'b0;
      have_bit_r <= 1'b0;
      perr_r     <= 1'b0;
      ferr_r     <= 1'b0;
      par_mode_r <= PAR_NONE;
      two_stop_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r    <= START;
            bit_cnt_r  <= '0;
            have_bit_r <= 1'b0;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
            par_mode_r <= parity_mode;
            two_stop_r <= two_stop;
          end
        end
        START: begin
          if (mid_s) state_r <= vote_s ? IDLE : DATA;
        end
        DATA: begin
          // have_bit_r masks the tail of the start bit, which ends in DATA
          if (mid_s) begin
            bit_r      <= vote_s;
            have_bit_r <= 1'b1;
          end else if (last_s && have_bit_r) begin
            shreg_r    <= {bit_r, shreg_r[DATA_BITS-1:1]};
            have_bit_r <= 1'b0;
            bit_cnt_r  <= bit_cnt_r + BW'(1);
            if (bit_cnt_r == B_LAST) state_r <= par_en_s ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (mid_s) begin
            perr_r  <= vote_s ^ par_exp_s;
            state_r <= STOP;
          end
        end
        STOP: begin
          if (mid_s) begin
            ferr_r  <= ferr_r | ~vote_s;
            state_r <= two_stop_r ? STOP2 : IDLE;
          end
        end
        STOP2: begin
          if (mid_s) state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // output register with valid/ready hand-off and overrun pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (finish_s) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg_r;
          parity_err <= perr_r;
          frame_err  <= ferr_r | ~vote_s;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
